// File: rtl/reg_file_pkg.sv
// Shared defaults for the multi-port register file with pending scoreboard.
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;
  localparam int DEF_NREAD = 2;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  // Register index for the default-sized file.
  typedef logic [DEF_AW-1:0] addr_t;

endpackage : reg_file_pkg

// File: rtl/rf_read_port.sv
// One registered read port: load enable, write-bypass mux and the
// RD_DATA/RD_PEND capture register.
module rf_read_port #(
  parameter int WIDTH  = 16,
  parameter int AW     = 3,
  parameter int BYPASS = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ld_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic [WIDTH-1:0] reg_data_i,
  input  logic             reg_pend_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             reissue_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_pend_o
);

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_pend_q, rd_pend_d;
  logic             wr_hit;

  // A same-cycle write to the address being read; only forwarded when bypassing.
  assign wr_hit = (BYPASS != 0) && we_i && (wr_addr_i == rd_addr_i);

  // Next capture value: hold unless loading, forward write data on a hit.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    rd_data_d = rd_data_q;
    rd_pend_d = rd_pend_q;
    if (ld_i) begin
      rd_data_d = wr_hit ? wr_data_i : reg_data_i;
      // A forwarded write clears the pending flag unless the same edge re-issues it.
      rd_pend_d = (wr_hit && !reissue_i) ? 1'b0 : reg_pend_i;
    end
  end

  // Capture register with synchronous clear.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      rd_data_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_pend_o = rd_pend_q;

endmodule : rf_read_port

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, NREAD registered read ports and
// a per-register pending scoreboard (set on issue, cleared on write).
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int NREAD  = DEF_NREAD,
  parameter int BYPASS = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   WE,
  input  logic [$clog2(NREGS)-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]       WR_DATA,
  input  logic                   ISSUE,
  input  logic [$clog2(NREGS)-1:0] ISSUE_ADDR,
  input  logic [NREAD-1:0]       LD_REG,
  input  logic [NREAD*$clog2(NREGS)-1:0] RD_ADDR,
  output logic [NREAD*WIDTH-1:0] RD_DATA,
  output logic [NREAD-1:0]       RD_PEND,
  output logic [NREGS-1:0]       PEND_VEC
);

  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic             reissue;

  // Issue and write hitting the same register in one cycle: issue wins.
  assign reissue = ISSUE && WE && (ISSUE_ADDR == WR_ADDR);

  // Storage array write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the array is cleared on reset because reads after reset must return zero.
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (WE) begin
      mem_q[WR_ADDR] <= WR_DATA;
    end
  end

  // Pending next state: write clears, then issue sets so it overrides a same-address write.
  always_comb begin
    pend_d = pend_q;
    if (WE)    pend_d[WR_ADDR]    = 1'b0;
    if (ISSUE) pend_d[ISSUE_ADDR] = 1'b1;
  end

  // Pending scoreboard register.
  always_ff @(posedge Clk) begin
    if (Reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign PEND_VEC = pend_q;

  for (genvar gp = 0; gp < NREAD; gp++) begin : g_port
    logic [AW-1:0] rd_addr;
    assign rd_addr = RD_ADDR[gp*AW +: AW];

    rf_read_port #(
      .WIDTH  (WIDTH),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_port (
      .Clk        (Clk),
      .Reset      (Reset),
      .ld_i       (LD_REG[gp]),
      .rd_addr_i  (rd_addr),
      .reg_data_i (mem_q[rd_addr]),
      .reg_pend_i (pend_q[rd_addr]),
      .we_i       (WE),
      .wr_addr_i  (WR_ADDR),
      .wr_data_i  (WR_DATA),
      .reissue_i  (reissue),
      .rd_data_o  (RD_DATA[gp*WIDTH +: WIDTH]),
      .rd_pend_o  (RD_PEND[gp])
    );
  end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a BYPASS=1 and a BYPASS=0 instance share
// stimulus; a reference model pushes expected port contents to a queue that
// is popped and compared after each clock edge.
module tb_reg_file_mp;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int R  = 2;
  localparam int AW = 3;

  logic              Clk;
  logic              Reset;
  logic              WE;
  logic [AW-1:0]     WR_ADDR;
  logic [W-1:0]      WR_DATA;
  logic              ISSUE;
  logic [AW-1:0]     ISSUE_ADDR;
  logic [R-1:0]      LD_REG;
  logic [R*AW-1:0]   RD_ADDR;
  logic [R*W-1:0]    rd_data_b1, rd_data_b0;
  logic [R-1:0]      rd_pend_b1, rd_pend_b0;
  logic [N-1:0]      pend_vec_b1, pend_vec_b0;

  reg_file_mp #(.WIDTH(W), .NREGS(N), .NREAD(R), .BYPASS(1)) dut_b1 (
    .Clk(Clk), .Reset(Reset), .WE(WE), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .ISSUE(ISSUE), .ISSUE_ADDR(ISSUE_ADDR), .LD_REG(LD_REG), .RD_ADDR(RD_ADDR),
    .RD_DATA(rd_data_b1), .RD_PEND(rd_pend_b1), .PEND_VEC(pend_vec_b1)
  );

  reg_file_mp #(.WIDTH(W), .NREGS(N), .NREAD(R), .BYPASS(0)) dut_b0 (
    .Clk(Clk), .Reset(Reset), .WE(WE), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .ISSUE(ISSUE), .ISSUE_ADDR(ISSUE_ADDR), .LD_REG(LD_REG), .RD_ADDR(RD_ADDR),
    .RD_DATA(rd_data_b0), .RD_PEND(rd_pend_b0), .PEND_VEC(pend_vec_b0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         port;
    logic [W-1:0] d1;
    logic [W-1:0] d0;
    logic       p1;
    logic       p0;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fails  = 0;

  // Reference model state.
  logic [W-1:0] m_mem [N];
  logic [N-1:0] m_pend;
  logic [W-1:0] m_rd1 [R];
  logic [W-1:0] m_rd0 [R];
  logic         m_p1  [R];
  logic         m_p0  [R];

  task automatic check(input string tag, input int port, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s port %0d: observed %h expected %h", tag, port, obs, exp);
    end
  endtask

  // Apply the currently driven inputs for one clock edge, then compare.
  task automatic step(input string tag);
    exp_t e;
    logic [AW-1:0] a;
    logic hit;
    for (int p = 0; p < R; p++) begin
      a = RD_ADDR[p*AW +: AW];
      if (Reset) begin
        m_rd1[p] = '0; m_rd0[p] = '0; m_p1[p] = 1'b0; m_p0[p] = 1'b0;
      end else if (LD_REG[p]) begin
        hit      = WE && (WR_ADDR == a);
        m_rd1[p] = hit ? WR_DATA : m_mem[a];
        m_rd0[p] = m_mem[a];
        m_p1[p]  = (hit && !(ISSUE && ISSUE_ADDR == WR_ADDR)) ? 1'b0 : m_pend[a];
        m_p0[p]  = m_pend[a];
      end
      e.port = p; e.d1 = m_rd1[p]; e.d0 = m_rd0[p]; e.p1 = m_p1[p]; e.p0 = m_p0[p];
      sb_q.push_back(e);
    end
    if (Reset) begin
      for (int i = 0; i < N; i++) m_mem[i] = '0;
      m_pend = '0;
    end else begin
      if (WE)    begin m_mem[WR_ADDR] = WR_DATA; m_pend[WR_ADDR] = 1'b0; end
      if (ISSUE) m_pend[ISSUE_ADDR] = 1'b1;
    end
    @(posedge Clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " data_b1"}, e.port, rd_data_b1[e.port*W +: W], e.d1);
      check({tag, " data_b0"}, e.port, rd_data_b0[e.port*W +: W], e.d0);
      check({tag, " pend_b1"}, e.port, W'(rd_pend_b1[e.port]), W'(e.p1));
      check({tag, " pend_b0"}, e.port, W'(rd_pend_b0[e.port]), W'(e.p0));
    end
    check({tag, " pendvec_b1"}, -1, W'(pend_vec_b1), W'(m_pend));
    check({tag, " pendvec_b0"}, -1, W'(pend_vec_b0), W'(m_pend));
  endtask

  task automatic idle();
    WE = 1'b0; ISSUE = 1'b0; LD_REG = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    WE = 1'b1; WR_ADDR = a; WR_DATA = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    LD_REG[p] = 1'b1; RD_ADDR[p*AW +: AW] = a;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_pend = '0;
    for (int p = 0; p < R; p++) begin
      m_rd1[p] = '0; m_rd0[p] = '0; m_p1[p] = 1'b0; m_p0[p] = 1'b0;
    end
    Reset = 1'b1; WR_ADDR = '0; WR_DATA = '0; ISSUE_ADDR = '0; RD_ADDR = '0;
    idle();
    #1;
    step("reset0");
    step("reset1");
    Reset = 1'b0;

    // Write R3, then reset with a write, issue and read presented: all discarded.
    idle(); wr(3'd3, 16'h1234); step("wr_r3");
    idle(); Reset = 1'b1; wr(3'd7, 16'h7777); ISSUE = 1'b1; ISSUE_ADDR = 3'd3;
    rd(0, 3'd3); step("reset_cycle");
    Reset = 1'b0;
    idle(); rd(0, 3'd3); rd(1, 3'd7); step("rd_after_reset");
    check("reset r3", 0, rd_data_b1[0 +: W], 16'h0000);
    check("reset pendvec", 0, W'(pend_vec_b1), 16'h0000);

    // Multi-read of two different registers.
    idle(); wr(3'd1, 16'hAAAA); step("wr_r1");
    idle(); wr(3'd6, 16'h5555); step("wr_r6");
    idle(); rd(0, 3'd1); rd(1, 3'd6); step("multi_rd");
    check("multi port0", 0, rd_data_b1[0 +: W], 16'hAAAA);
    check("multi port1", 1, rd_data_b1[W +: W], 16'h5555);

    // Both ports read the same address.
    idle(); rd(0, 3'd6); rd(1, 3'd6); step("same_addr");

    // Same-cycle write and read of R2: forwarded only in the BYPASS=1 build.
    idle(); wr(3'd2, 16'hBEEF); rd(0, 3'd2); rd(1, 3'd1); step("bypass");
    check("bypass b1", 0, rd_data_b1[0 +: W], 16'hBEEF);
    check("bypass b0", 0, rd_data_b0[0 +: W], 16'h0000);

    // Scoreboard: issue R5, read it pending, write it, read it clear.
    idle(); ISSUE = 1'b1; ISSUE_ADDR = 3'd5; step("issue_r5");
    check("issue pendvec5", 0, W'(pend_vec_b1[5]), 16'h0001);
    idle(); ISSUE = 1'b1; ISSUE_ADDR = 3'd5; rd(0, 3'd5); step("reissue_r5");
    check("rd pend r5", 0, W'(rd_pend_b1[0]), 16'h0001);
    idle(); wr(3'd5, 16'h0042); rd(1, 3'd5); step("wr_r5_bypass");
    idle(); rd(0, 3'd5); step("rd_r5");
    check("r5 data", 0, rd_data_b1[0 +: W], 16'h0042);
    check("r5 pend", 0, W'(rd_pend_b1[0]), 16'h0000);

    // Write to a register that is not pending.
    idle(); wr(3'd0, 16'h0F0F); step("wr_nonpend");

    // Issue and write R4 together: data written, bit stays set.
    idle(); wr(3'd4, 16'h0777); ISSUE = 1'b1; ISSUE_ADDR = 3'd4; rd(1, 3'd2); step("issue_wr_r4");
    check("issue_wr pend4", 0, W'(pend_vec_b1[4]), 16'h0001);
    idle(); rd(0, 3'd4); rd(1, 3'd0); step("rd_r4");
    check("r4 data", 0, rd_data_b1[0 +: W], 16'h0777);

    // Hold: no loads for 5 cycles while R1 is rewritten.
    idle(); rd(0, 3'd1); rd(1, 3'd1); step("hold_load");
    for (int k = 0; k < 5; k++) begin
      idle(); RD_ADDR = {3'd1, 3'd1}; wr(3'd1, W'(16'h1000 + k)); step("hold");
    end
    check("hold port0", 0, rd_data_b1[0 +: W], 16'hAAAA);
    idle(); rd(0, 3'd1); step("hold_after");

    // Issue to R7 and write R7 with mixed traffic on the other port.
    idle(); ISSUE = 1'b1; ISSUE_ADDR = 3'd7; rd(0, 3'd7); rd(1, 3'd3); step("issue_r7");
    idle(); wr(3'd7, 16'hFFFF); rd(0, 3'd7); step("wr_r7");
    idle(); step("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_reg_file_mp
